// File: rtl/usb3_skp_scheduler.sv
// TX SKP scheduler: earns SKP ordered-set credits from transmitted symbols and
// inserts a full SKP word (2 ordered sets) at packet boundaries.
module usb3_skp_scheduler #(
  parameter int unsigned SKP_INTERVAL = 354,
  parameter int unsigned MAX_CREDIT   = 4,
  parameter int unsigned CNT_W        = 9
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_pkt_active,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_skp,
  output logic [2:0]  credit_count,
  output logic        err_skp_overrun
);

  localparam int unsigned SYMS_PER_CYCLE = 4;
  localparam logic [31:0] SKP_WORD       = 32'h3C3C_3C3C;
  localparam logic [3:0]  SKP_K          = 4'hF;

  typedef enum logic {PASS, SKIP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d, sym_next;
  logic [2:0]       credit_d;
  logic             err_d;
  logic [31:0]      data_d;
  logic [3:0]       datak_d;
  logic             insert;
  logic             earn;

  assign sym_next = sym_cnt_q + CNT_W'(SYMS_PER_CYCLE);
  assign insert   = enable && (credit_count >= 3'd2) && !in_pkt_active;
  assign in_ready = !insert;
  assign out_skp  = (state_q == SKIP);

  // Next-state, credit accounting and output word selection
  always_comb begin
    state_d   = PASS;
    sym_cnt_d = sym_cnt_q;
    credit_d  = credit_count;
    err_d     = err_skp_overrun;
    earn      = 1'b0;
    data_d    = 32'h0;
    datak_d   = 4'h0;

    if (insert) begin
      state_d = SKIP;
    end

    if (!enable) begin
      sym_cnt_d = '0;
      credit_d  = 3'd0;
    end else if (insert) begin
      credit_d = credit_count - 3'd2;
    end else begin
      if (sym_next >= CNT_W'(SKP_INTERVAL)) begin
        sym_cnt_d = sym_next - CNT_W'(SKP_INTERVAL);
        earn      = 1'b1;
      end else begin
        sym_cnt_d = sym_next;
      end
      if (earn) begin
        if (credit_count >= 3'(MAX_CREDIT)) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_count + 3'd1;
        end
      end
    end

    if (state_d == SKIP) begin
      data_d  = SKP_WORD;
      datak_d = SKP_K;
    end else if (in_valid) begin
      data_d  = in_data;
      datak_d = in_datak;
    end
  end

  // State and output registers
  always_ff @(posedge local_clk) begin
    if (reset) begin
      state_q         <= PASS;
      sym_cnt_q       <= '0;
      credit_count    <= 3'd0;
      err_skp_overrun <= 1'b0;
      out_data        <= 32'h0;
      out_datak       <= 4'h0;
    end else begin
      state_q         <= state_d;
      sym_cnt_q       <= sym_cnt_d;
      credit_count    <= credit_d;
      err_skp_overrun <= err_d;
      out_data        <= data_d;
      out_datak       <= datak_d;
    end
  end

endmodule
